// File: rtl/add_sub_result_stage.sv
// Result stage behind the ripple adder/subtractor: captures sum plus Z/N/C/V flags into a small FIFO.
// Optional sticky overflow register enabled by defining ADDSUB_STICKY_OVF_EN.
module add_sub_result_stage #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic [WIDTH-1:0] in_s,
    input  logic             in_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_z,
    output logic             out_n,
    output logic             out_c,
    output logic             out_v
`ifdef ADDSUB_STICKY_OVF_EN
    ,
    input  logic             clr_sticky,
    output logic             sticky_v
`endif
);

    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH-1:0] mem_s [DEPTH];
    logic [3:0]       mem_f [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;

    logic push, pop;
    logic f_z, f_n, f_c, f_v;

    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Subtract flags use the raw in_b; the adder's cin=1 makes cout a "no borrow" indication.
    always_comb begin
        f_z = (in_s == '0);
        f_n = in_s[MSB];
        f_c = in_sub ? ~in_cout : in_cout;
        if (in_sub)
            f_v = (in_a[MSB] != in_b[MSB]) && (in_s[MSB] != in_a[MSB]);
        else
            f_v = (in_a[MSB] == in_b[MSB]) && (in_s[MSB] != in_a[MSB]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_s[i] <= '0;
                mem_f[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_s[wr_ptr] <= in_s;
                mem_f[wr_ptr] <= {f_z, f_n, f_c, f_v};
                wr_ptr        <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    assign out_s = mem_s[rd_ptr];
    assign {out_z, out_n, out_c, out_v} = mem_f[rd_ptr];

`ifdef ADDSUB_STICKY_OVF_EN
    // Set takes priority over clear so a coincident overflow is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sticky_v <= 1'b0;
        else if (push && f_v)
            sticky_v <= 1'b1;
        else if (clr_sticky)
            sticky_v <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_add_sub_result_stage.sv
// Self-checking bench for add_sub_result_stage: table vectors, hand sequences and randomized traffic
// against a queue-based arithmetic reference model.
module tb_add_sub_result_stage;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, in_sub = 1'b0, in_cout = 1'b0, out_ready = 1'b0;
    logic [7:0] in_a = '0, in_b = '0, in_s = '0;
    logic       in_ready, out_valid, out_z, out_n, out_c, out_v;
    logic [7:0] out_s;
`ifdef ADDSUB_STICKY_OVF_EN
    logic       clr_sticky = 1'b0;
    logic       sticky_v;
`endif

    always #5 clk = ~clk;

    add_sub_result_stage #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_s(in_s), .in_cout(in_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_z(out_z), .out_n(out_n), .out_c(out_c), .out_v(out_v)
`ifdef ADDSUB_STICKY_OVF_EN
        , .clr_sticky(clr_sticky), .sticky_v(sticky_v)
`endif
    );

    typedef struct {
        logic [7:0] s;
        logic       z, n, c, v;
    } ent_t;

    typedef struct {
        logic [7:0] a, b;
        logic       sub;
        logic [7:0] s;
        logic       cout;
        ent_t       exp;
    } vec_t;

    ent_t q[$];
    logic sticky_m = 1'b0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: flags from the true integer results of the operation.
    function automatic ent_t model(input logic [7:0] a, input logic [7:0] b, input logic sub);
        ent_t e;
        int sa = $signed(a);
        int sb = $signed(b);
        int r  = sub ? sa - sb : sa + sb;
        e.s = sub ? a - b : a + b;
        e.z = (e.s == 8'd0);
        e.n = e.s[7];
        e.c = sub ? (a < b) : ((int'(a) + int'(b)) > 255);
        e.v = (r > 127) || (r < -128);
        return e;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".out_valid"}, int'(out_valid), int'(q.size() != 0));
        chk({tag, ".in_ready"}, int'(in_ready), int'(q.size() < DEPTH));
        if (q.size() != 0) begin
            chk({tag, ".out_s"}, int'(out_s), int'(q[0].s));
            chk({tag, ".flags"}, int'({out_z, out_n, out_c, out_v}),
                int'({q[0].z, q[0].n, q[0].c, q[0].v}));
        end
`ifdef ADDSUB_STICKY_OVF_EN
        chk({tag, ".sticky_v"}, int'(sticky_v), int'(sticky_m));
`endif
    endtask

    // One clock: drive inputs, advance model at the edge, check #1 after it.
    task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b, input logic sub,
                         input logic [7:0] s, input logic cout, input logic rdy, input logic clr,
                         input string tag);
        logic push, pop;
        ent_t e;
        in_valid = v; in_a = a; in_b = b; in_sub = sub; in_s = s; in_cout = cout;
        out_ready = rdy;
`ifdef ADDSUB_STICKY_OVF_EN
        clr_sticky = clr;
`endif
        push = v && (q.size() < DEPTH);
        pop  = rdy && (q.size() != 0);
        e = model(a, b, sub);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
        if (push && e.v) sticky_m = 1'b1;
        else if (clr) sticky_m = 1'b0;
        #1;
        check_state(tag);
    endtask

    task automatic op(input logic v, input logic [7:0] a, input logic [7:0] b, input logic sub,
                      input logic rdy, input logic clr, input string tag);
        logic [8:0] t;
        t = sub ? ({1'b0, a} + {1'b0, ~b} + 9'd1) : ({1'b0, a} + {1'b0, b});
        cycle(v, a, b, sub, t[7:0], t[8], rdy, clr, tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".out_valid"}, int'(out_valid), 0);
        chk({tag, ".in_ready"}, int'(in_ready), 1);
        chk({tag, ".out_s"}, int'(out_s), 0);
        chk({tag, ".flags"}, int'({out_z, out_n, out_c, out_v}), 0);
`ifdef ADDSUB_STICKY_OVF_EN
        chk({tag, ".sticky_v"}, int'(sticky_v), 0);
`endif
    endtask

    initial begin
        vec_t vt[7];
        logic [7:0] held_s;
        logic [3:0] held_f;
        vt[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, '{8'h80, 1'b0, 1'b1, 1'b0, 1'b1}};
        vt[1] = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b1, '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0}};
        vt[2] = '{8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, '{8'hFE, 1'b0, 1'b1, 1'b1, 1'b0}};
        vt[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, '{8'h7F, 1'b0, 1'b0, 1'b0, 1'b1}};
        vt[4] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0}};
        vt[5] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0}};
        vt[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, '{8'h00, 1'b1, 1'b0, 1'b1, 1'b1}};

        // Reset state, asserted from time 0
        #1 check_zero("reset");
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        check_zero("post_reset");

        // Table vectors with out_ready held high
        foreach (vt[i]) begin
            cycle(1'b1, vt[i].a, vt[i].b, vt[i].sub, vt[i].s, vt[i].cout, 1'b1, 1'b0, "vec");
            chk($sformatf("vec%0d.s", i), int'(out_s), int'(vt[i].exp.s));
            chk($sformatf("vec%0d.zncv", i), int'({out_z, out_n, out_c, out_v}),
                int'({vt[i].exp.z, vt[i].exp.n, vt[i].exp.c, vt[i].exp.v}));
        end
        op(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, "drain");

        // Backpressure: A, B, C with consumer stalled
        op(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0, "bp_A");
        held_s = out_s; held_f = {out_z, out_n, out_c, out_v};
        op(1'b1, 8'h40, 8'h50, 1'b0, 1'b0, 1'b0, "bp_B");
        chk("bp_full_in_ready", int'(in_ready), 0);
        op(1'b1, 8'h90, 8'h10, 1'b1, 1'b0, 1'b0, "bp_C_held");
        op(1'b1, 8'h90, 8'h10, 1'b1, 1'b0, 1'b0, "bp_C_held2");
        chk("bp_stable_s", int'(out_s), int'(held_s));
        chk("bp_stable_f", int'({out_z, out_n, out_c, out_v}), int'(held_f));
        chk("bp_head_A", int'(out_s), 8'h33);
        op(1'b1, 8'h90, 8'h10, 1'b1, 1'b1, 1'b0, "bp_pop_A");
        chk("bp_head_B", int'(out_s), 8'h90);
        op(1'b1, 8'h90, 8'h10, 1'b1, 1'b1, 1'b0, "bp_pushC_popB");
        chk("bp_head_C", int'(out_s), 8'h80);
        op(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "bp_pop_C");
        chk("bp_empty", int'(out_valid), 0);

        // Count=1 with simultaneous push and pop
        op(1'b1, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, "pp_fill1");
        op(1'b1, 8'h0A, 8'h03, 1'b1, 1'b1, 1'b0, "pp_both");
        chk("pp_head_new", int'(out_s), 8'h07);
        op(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "pp_drain");
        chk("pp_single", int'(out_valid), 0);

`ifdef ADDSUB_STICKY_OVF_EN
        op(1'b1, 8'h80, 8'h01, 1'b1, 1'b1, 1'b0, "st_set");
        chk("st_set_direct", int'(sticky_v), 1);
        op(1'b1, 8'h10, 8'h01, 1'b0, 1'b1, 1'b0, "st_persist");
        chk("st_persist_direct", int'(sticky_v), 1);
        op(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, "st_clr");
        chk("st_clr_direct", int'(sticky_v), 0);
        op(1'b1, 8'h7F, 8'h7F, 1'b0, 1'b1, 1'b1, "st_clr_vs_set");
        chk("st_set_wins", int'(sticky_v), 1);
        op(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "st_drain");
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            op(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom),
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0), "rnd");

        // Reset asserted mid-handshake with two entries queued
        while (q.size() < DEPTH)
            op(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0, "rst_fill");
        op(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, "rst_full");
        in_valid = 1'b1; out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_zero("rst_mid");
        q.delete();
        sticky_m = 1'b0;
        @(posedge clk); #1;
        check_zero("rst_held");
        #2 rst_n = 1'b1;
        op(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, "rst_first_push");
        chk("rst_first_s", int'(out_s), 8'h80);
        chk("rst_first_in_ready", int'(in_ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
